// File: rtl/mt_sequencer.sv
// Machine-cycle / T-state sequencer: one-hot M and T vectors, WAIT insertion and bus release.
// Optional feature: define AUTO_IOWAIT_EN to force one Tw on IO cycles.
module mt_sequencer #(
  parameter int NUM_M = 6,
  parameter int NUM_T = 6
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             nextM,
  input  logic             setM1,
  input  logic             mem_io_cyc,
  input  logic             io_cyc,
  input  logic             nwait,
  input  logic             busrq,
  output logic [NUM_M-1:0] m_state,
  output logic [NUM_T-1:0] t_state,
  output logic             busack,
  output logic             in_wait,
  output logic             seq_err
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    TWAIT  = 2'd1,
    BUSREL = 2'd2
  } state_t;

  localparam logic [NUM_M-1:0] M_FIRST  = NUM_M'(1);
  localparam logic [NUM_T-1:0] T_FIRST  = NUM_T'(1);
  localparam logic [NUM_T-1:0] T_SECOND = NUM_T'(2);
  localparam logic [NUM_T-1:0] T_THIRD  = NUM_T'(4);

  state_t           state_reg, state_next;
  logic [NUM_M-1:0] m_reg, m_next;
  logic [NUM_T-1:0] t_reg, t_next;
  logic [NUM_M-1:0] target_reg, target_next;
  logic [NUM_M-1:0] m_target;
  logic             err_reg, err_next;
  logic             auto_due;

`ifdef AUTO_IOWAIT_EN
  // An IO cycle always gets its first Tw; further Tw come only from nwait.
  assign auto_due = io_cyc;
`else
  logic unused_io_cyc;
  assign unused_io_cyc = io_cyc;
  assign auto_due      = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg  <= RUN;
      m_reg      <= M_FIRST;
      t_reg      <= T_FIRST;
      target_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      m_reg      <= m_next;
      t_reg      <= t_next;
      target_reg <= target_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    m_next      = m_reg;
    t_next      = t_reg;
    target_next = target_reg;
    err_next    = 1'b0;
    m_target    = M_FIRST;

    case (state_reg)
      RUN: begin
        if (setM1 || nextM) begin
          if (setM1) begin
            m_target = M_FIRST;
          end else if (m_reg[NUM_M-1]) begin
            // nextM past the last machine cycle: recover to M1 and flag it
            m_target = M_FIRST;
            err_next = 1'b1;
          end else begin
            m_target = {m_reg[NUM_M-2:0], 1'b0};
          end
          // Bus request is honoured only here, at a machine-cycle boundary
          if (busrq) begin
            target_next = m_target;
            m_next      = '0;
            t_next      = '0;
            state_next  = BUSREL;
          end else begin
            m_next = m_target;
            t_next = T_FIRST;
          end
        end else if ((t_reg == T_SECOND) && mem_io_cyc && (!nwait || auto_due)) begin
          state_next = TWAIT;
        end else if (t_reg[NUM_T-1]) begin
          // Ran off the end of the M-cycle without a request from execute
          t_next   = T_FIRST;
          err_next = 1'b1;
        end else begin
          t_next = {t_reg[NUM_T-2:0], 1'b0};
        end
      end

      TWAIT: begin
        if (nwait) begin
          t_next     = T_THIRD;
          state_next = RUN;
        end
      end

      BUSREL: begin
        if (!busrq) begin
          m_next     = target_reg;
          t_next     = T_FIRST;
          state_next = RUN;
        end
      end

      default: begin
        state_next = RUN;
        m_next     = M_FIRST;
        t_next     = T_FIRST;
      end
    endcase
  end

  assign m_state = m_reg;
  assign t_state = t_reg;
  assign busack  = (state_reg == BUSREL);
  assign in_wait = (state_reg == TWAIT);
  assign seq_err = err_reg;

endmodule
